// File: rtl/bcd_ascii_streamer.sv
// Streams a packed BCD word as ASCII characters, MSD first, over a byte-wide valid/ready port.
// Optional CR/LF trailer is compiled in when BCD_STREAM_CRLF_EN is defined.
module bcd_ascii_streamer #(
   parameter int N_DIGITS    = 10,
   parameter bit SUPPRESS_LZ = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [4*N_DIGITS-1:0]   bcd_in,
   output logic                    busy,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   input  logic                    tx_ready,
   output logic                    done
);

   localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam logic [IW-1:0] IDX_TOP = IW'(N_DIGITS - 1);

`ifdef BCD_STREAM_CRLF_EN
   typedef enum logic [2:0] {S_IDLE, S_SKIP, S_SEND, S_CR, S_LF, S_DONE} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_SKIP, S_SEND, S_DONE} state_t;
`endif

   state_t                  state, state_n;
   logic [IW-1:0]           idx, idx_n, idx_dec;
   logic [4*N_DIGITS-1:0]   word, word_n;
   logic [7:0]              data_q, data_n;
   logic                    valid_q, valid_n;
   logic [3:0]              cur_digit, next_digit;

   function automatic logic [7:0] to_ascii(input logic [3:0] d);
      return (d > 4'd9) ? 8'h3F : {4'h3, d};
   endfunction

   assign idx_dec    = idx - IW'(1);
   assign cur_digit  = word[{idx, 2'b00} +: 4];
   assign next_digit = word[{idx_dec, 2'b00} +: 4];

   // tx_data/tx_valid are carried as state so they hold steady while the sink stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         idx     <= '0;
         word    <= '0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         word    <= word_n;
         data_q  <= data_n;
         valid_q <= valid_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      word_n  = word;
      data_n  = data_q;
      valid_n = valid_q;
      case (state)
         S_IDLE: begin
            if (start) begin
               word_n  = bcd_in;
               idx_n   = IDX_TOP;
               state_n = S_SKIP;
            end
         end
         S_SKIP: begin
            if (SUPPRESS_LZ && cur_digit == 4'd0 && idx != '0) begin
               idx_n = idx_dec;
            end else begin
               state_n = S_SEND;
               valid_n = 1'b1;
               data_n  = to_ascii(cur_digit);
            end
         end
         S_SEND: begin
            if (valid_q && tx_ready) begin
               if (idx == '0) begin
`ifdef BCD_STREAM_CRLF_EN
                  state_n = S_CR;
                  data_n  = 8'h0D;
`else
                  state_n = S_DONE;
                  valid_n = 1'b0;
`endif
               end else begin
                  idx_n  = idx_dec;
                  data_n = to_ascii(next_digit);
               end
            end
         end
`ifdef BCD_STREAM_CRLF_EN
         S_CR: begin
            if (valid_q && tx_ready) begin
               state_n = S_LF;
               data_n  = 8'h0A;
            end
         end
         S_LF: begin
            if (valid_q && tx_ready) begin
               state_n = S_DONE;
               valid_n = 1'b0;
            end
         end
`endif
         S_DONE: begin
            state_n = S_IDLE;
         end
         default: begin
            state_n = S_IDLE;
            valid_n = 1'b0;
         end
      endcase
   end

   always_comb begin
      busy     = (state != S_IDLE);
      done     = (state == S_DONE);
      tx_data  = data_q;
      tx_valid = valid_q;
   end

endmodule
